icache_fill_ctrl: RTL and testbench
===================================

Name: icache_fill_ctrl

Overview:
- Miss/refill controller for the fetch stage's instruction cache.
- On a cache miss it stalls the PC and fetches the whole line from main memory one word at a time over a req/ack handshake.
- It writes each word and then the tag/valid into the cache, and holds back any branch redirect that arrives during the refill.
- Sits between the fetch stage (PC, cache arrays) and the memory port.

Parameters:
- ADDR_W, 16: PC / memory address width.
- DATA_W, 16: instruction word width.
- LINE_WORDS, 4: words per cache line; power of 2, ≥2. Internal OFF_W = log2(LINE_WORDS).
- CNT_W, 16: miss counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetchValid  in  1  fetch stage presents a valid PC this cycle
- addressIn  in  ADDR_W  current PC
- hitIn  in  1  cache hit for addressIn
- PcSrc  in  1  branch redirect request from execute
- BranchTarget  in  ADDR_W  redirect target
- stallOut  out  1  hold PC / fetch register
- memReq  out  1  memory read request
- memAddr  out  ADDR_W  memory word address
- memAck  in  1  memData valid; completes current request
- memData  in  DATA_W  read data
- fillWe  out  1  cache data-array write enable
- fillAddr  out  ADDR_W  data-array write address
- fillData  out  DATA_W  data-array write data
- tagWe  out  1  tag/valid write enable
- tagAddr  out  ADDR_W  line base address for tag write
- pcSrcOut  out  1  redirect to PC mux
- branchTargetOut  out  ADDR_W  redirect target to PC mux
- missCount  out  CNT_W  saturating miss counter

Behaviour:
- Clock is clk. Reset is asynchronous, active-low (rst_n).
- FSM states: IDLE, REQ, TAGWR, DONE. Reset goes to IDLE.
- Reset clears lineBase, wordCnt, branchPending, pendingTarget and missCount (missCount=0).
- While in reset: memReq=0, fillWe=0, tagWe=0; stallOut/pcSrcOut follow the IDLE equations.
- Reset mid-refill: memReq drops immediately. No tag write occurs, so the line stays invalid. The memory side must tolerate an abandoned request.
- IDLE:
  - pcSrcOut=PcSrc, branchTargetOut=BranchTarget (combinational pass-through).
  - miss = fetchValid & ~hitIn & ~PcSrc. A redirect wins over a miss, so no fill starts for a wrong-path PC.
  - stallOut=miss, combinational, same cycle.
  - On miss: lineBase <= addressIn with low OFF_W bits cleared; wordCnt <= 0; missCount++ (saturates at all-ones); go to REQ.
- REQ:
  - memReq=1, memAddr = lineBase | wordCnt.
  - Hold memReq and memAddr stable until memAck.
  - In the memAck cycle: fillWe=1, fillAddr=memAddr, fillData=memData (combinational), and wordCnt++.
  - If wordCnt==LINE_WORDS-1 in the ack cycle, go to TAGWR; otherwise stay in REQ with memReq still high.
  - Back-to-back acks give one word per cycle.
- TAGWR: tagWe=1, tagAddr=lineBase, for exactly one cycle, then go to DONE.
- DONE: one cycle, then go to IDLE.
  - pcSrcOut = PcSrc | branchPending.
  - branchTargetOut = PcSrc ? BranchTarget : pendingTarget.
  - Clear branchPending.
- stallOut=1 in REQ, TAGWR and DONE.
- Fetch-stage contract: pcSrcOut has priority over stallOut at the PC mux.
- PcSrc during REQ/TAGWR: set branchPending=1 and capture pendingTarget. A later PcSrc overwrites the target (last wins). pcSrcOut=0 in these states.
- fetchValid, hitIn and addressIn are ignored outside IDLE.
- Miss latency with zero-wait memory: stall lasts 1 (IDLE) + LINE_WORDS + 1 (TAGWR) + 1 (DONE) cycles, i.e. 7 cycles at default parameters.
- memAck outside REQ is ignored.
- memReq, fillWe and tagWe are never asserted in the same cycle as each other, except memReq with fillWe in an ack cycle.

Test Plan:
- Hits only: fetchValid=1, hitIn=1, 20 cycles -> stallOut=0, memReq never 1, missCount=0.
- Miss at addressIn=0x0046, memAck every cycle, memData=0xA000+word -> memAddr 0x0044..0x0047 with fillWe on 4 consecutive cycles (fillData 0xA000..0xA003); tagWe once with tagAddr=0x0044; stallOut high exactly 7 cycles; missCount=1.
- Same miss with 2 wait cycles per ack -> memAddr holds for 3 cycles per word; stallOut high 1+12+1+1=15 cycles; exactly 4 fillWe pulses.
- PcSrc=1 with BranchTarget=0x0100 in the 2nd REQ cycle, then 0x0200 during TAGWR -> pcSrcOut=0 until DONE; in DONE pcSrcOut=1 and branchTargetOut=0x0200; next IDLE cycle has no pending branch.
- Miss and PcSrc=1 in the same IDLE cycle -> no refill, missCount unchanged, pcSrcOut=1 the same cycle.
- rst_n low after the 2nd ack of a fill -> memReq=0 immediately, tagWe never pulses, state IDLE, missCount=0. With CNT_W=2, 5 misses -> missCount=3.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/refill controller: stalls fetch, streams a line from
// memory word by word, writes tag/valid last, and defers redirects seen mid-refill.
module icache_fill_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetchValid,
  input  logic [ADDR_W-1:0] addressIn,
  input  logic              hitIn,
  input  logic              PcSrc,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              stallOut,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic              fillWe,
  output logic [ADDR_W-1:0] fillAddr,
  output logic [DATA_W-1:0] fillData,
  output logic              tagWe,
  output logic [ADDR_W-1:0] tagAddr,
  output logic              pcSrcOut,
  output logic [ADDR_W-1:0] branchTargetOut,
  output logic [CNT_W-1:0]  missCount
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    TAGWR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   lineBase_r;
  logic [OFF_W-1:0]    wordCnt_r;
  logic                branchPending_r;
  logic [ADDR_W-1:0]   pendingTarget_r;
  logic [CNT_W-1:0]    missCount_r;
  logic                miss_s;
  logic [ADDR_W-1:0]   wordAddr_s;

  // A redirect outranks a miss so no refill starts for a wrong-path PC.
  assign miss_s     = (state_r == IDLE) & fetchValid & ~hitIn & ~PcSrc;
  assign wordAddr_s = lineBase_r | {{(ADDR_W-OFF_W){1'b0}}, wordCnt_r};
  assign missCount  = missCount_r;
  assign memAddr    = wordAddr_s;
  assign fillAddr   = wordAddr_s;
  assign fillData   = memData;
  assign tagAddr    = lineBase_r;

  // Per-state output decode; stall and write strobes must act in the same cycle.
  always_comb begin
    stallOut        = 1'b1;
    memReq          = 1'b0;
    fillWe          = 1'b0;
    tagWe           = 1'b0;
    pcSrcOut        = 1'b0;
    branchTargetOut = BranchTarget;
    case (state_r)
      IDLE: begin
        stallOut = miss_s;
        pcSrcOut = PcSrc;
      end
      REQ: begin
        memReq = 1'b1;
        if (memAck) begin
          fillWe = 1'b1;
        end else begin
          fillWe = 1'b0;
        end
      end
      TAGWR: begin
        tagWe = 1'b1;
      end
      DONE: begin
        pcSrcOut = PcSrc | branchPending_r;
        if (PcSrc) begin
          branchTargetOut = BranchTarget;
        end else begin
          branchTargetOut = pendingTarget_r;
        end
      end
      default: begin
        stallOut = 1'b1;
      end
    endcase
  end

  // Refill sequencing, word counter, deferred redirect and miss statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      lineBase_r      <= {ADDR_W{1'b0}};
      wordCnt_r       <= {OFF_W{1'b0}};
      branchPending_r <= 1'b0;
      pendingTarget_r <= {ADDR_W{1'b0}};
      missCount_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            lineBase_r <= addressIn & LINE_MASK;
            wordCnt_r  <= {OFF_W{1'b0}};
            if (missCount_r != {CNT_W{1'b1}}) begin
              missCount_r <= missCount_r + CNT_W'(1);
            end
            state_r <= REQ;
          end
        end
        REQ: begin
          if (PcSrc) begin
            branchPending_r <= 1'b1;
            pendingTarget_r <= BranchTarget;
          end
          if (memAck) begin
            wordCnt_r <= wordCnt_r + OFF_W'(1);
            if (wordCnt_r == LAST_WORD) begin
              state_r <= TAGWR;
            end
          end
        end
        TAGWR: begin
          if (PcSrc) begin
            branchPending_r <= 1'b1;
            pendingTarget_r <= BranchTarget;
          end
          state_r <= DONE;
        end
        DONE: begin
          branchPending_r <= 1'b0;
          state_r         <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: fills, wait states, deferred redirect,
// redirect-vs-miss priority, reset mid-refill and counter saturation.
module tb_icache_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetchValid;
  logic [15:0] addressIn;
  logic        hitIn;
  logic        PcSrc;
  logic [15:0] BranchTarget;
  logic        memAck;
  logic [15:0] memData;

  logic        stallOut, memReq, fillWe, tagWe, pcSrcOut;
  logic [15:0] memAddr, fillAddr, fillData, tagAddr, branchTargetOut, missCount;

  logic        stallOut2, memReq2, fillWe2, tagWe2, pcSrcOut2;
  logic [15:0] memAddr2, fillAddr2, fillData2, tagAddr2, branchTargetOut2;
  logic [1:0]  missCount2;

  int checks = 0;
  int errors = 0;

  icache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetchValid(fetchValid), .addressIn(addressIn),
    .hitIn(hitIn), .PcSrc(PcSrc), .BranchTarget(BranchTarget), .stallOut(stallOut),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .fillWe(fillWe), .fillAddr(fillAddr), .fillData(fillData), .tagWe(tagWe),
    .tagAddr(tagAddr), .pcSrcOut(pcSrcOut), .branchTargetOut(branchTargetOut),
    .missCount(missCount)
  );

  icache_fill_ctrl #(.CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .fetchValid(fetchValid), .addressIn(addressIn),
    .hitIn(hitIn), .PcSrc(PcSrc), .BranchTarget(BranchTarget), .stallOut(stallOut2),
    .memReq(memReq2), .memAddr(memAddr2), .memAck(memAck), .memData(memData),
    .fillWe(fillWe2), .fillAddr(fillAddr2), .fillData(fillData2), .tagWe(tagWe2),
    .tagAddr(tagAddr2), .pcSrcOut(pcSrcOut2), .branchTargetOut(branchTargetOut2),
    .missCount(missCount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setHit();
    fetchValid   = 1'b1;
    hitIn        = 1'b1;
    addressIn    = 16'h0010;
    PcSrc        = 1'b0;
    BranchTarget = 16'h0000;
    memAck       = 1'b0;
    memData      = 16'h0000;
  endtask

  task automatic test_reset();
    fetchValid = 1'b1; hitIn = 1'b0; addressIn = 16'h0046;
    PcSrc = 1'b0; BranchTarget = 16'h0000; memAck = 1'b1; memData = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || fillWe !== 1'b0 || tagWe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes memReq=%b fillWe=%b tagWe=%b required 0 0 0", memReq, fillWe, tagWe);
    end
    checks++;
    if (missCount !== 16'h0000) begin
      errors++;
      $display("FAIL reset_missCount got %h required 0000", missCount);
    end
    checks++;
    if (stallOut !== 1'b1 || pcSrcOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_eqn stallOut=%b pcSrcOut=%b required 1 0", stallOut, pcSrcOut);
    end
    PcSrc = 1'b1; BranchTarget = 16'h0123;
    #1;
    checks++;
    if (stallOut !== 1'b0 || pcSrcOut !== 1'b1 || branchTargetOut !== 16'h0123) begin
      errors++;
      $display("FAIL reset_redirect stallOut=%b pcSrcOut=%b tgt=%h required 0 1 0123",
               stallOut, pcSrcOut, branchTargetOut);
    end
    @(negedge clk);
    setHit();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hits();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      setHit();
      #1;
      if (stallOut !== 1'b0 || memReq !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hits_nostall bad_cycles=%0d required 0", bad);
    end
    checks++;
    if (missCount !== 16'h0000) begin
      errors++;
      $display("FAIL hits_missCount got %h required 0000", missCount);
    end
  endtask

  task automatic test_fill(input int waitCyc, input logic [15:0] expMiss);
    int  word = 0;
    int  wc = 0;
    int  stallCnt = 0;
    int  fillCnt = 0;
    int  tagCnt = 0;
    bit  done = 1'b0;
    int  expStall = 3 + 4 * (waitCyc + 1);
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      setHit();
      if (c == 0) begin
        hitIn = 1'b0; addressIn = 16'h0046;
      end
      memAck  = memReq && (wc == waitCyc);
      memData = 16'hA000 + 16'(word);
      #1;
      if (c == 0) begin
        checks++;
        if (stallOut !== 1'b1) begin
          errors++;
          $display("FAIL fill_stall_same_cycle got %b required 1", stallOut);
        end
      end
      if (!stallOut && c > 0) begin
        done = 1'b1;
      end else begin
        stallCnt++;
        if (memReq) begin
          checks++;
          if (memAddr !== 16'h0044 + 16'(word)) begin
            errors++;
            $display("FAIL fill_memAddr got %h required %h", memAddr, 16'h0044 + 16'(word));
          end
        end
        if (fillWe) begin
          fillCnt++;
          checks++;
          if (fillAddr !== 16'h0044 + 16'(word) || fillData !== 16'hA000 + 16'(word)) begin
            errors++;
            $display("FAIL fill_write addr=%h data=%h required %h %h", fillAddr, fillData,
                     16'h0044 + 16'(word), 16'hA000 + 16'(word));
          end
        end
        if (tagWe) begin
          tagCnt++;
          checks++;
          if (tagAddr !== 16'h0044) begin
            errors++;
            $display("FAIL fill_tagAddr got %h required 0044", tagAddr);
          end
        end
        if ((memReq && tagWe) || (fillWe && tagWe) || (fillWe && !memAck)) begin
          checks++;
          errors++;
          $display("FAIL fill_exclusive memReq=%b fillWe=%b tagWe=%b memAck=%b required exclusive",
                   memReq, fillWe, tagWe, memAck);
        end
        if (memReq && memAck) begin
          word++;
          wc = 0;
        end else if (memReq) begin
          wc++;
        end
      end
    end
    memAck = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fill_timeout stall never released required release");
    end
    checks++;
    if (stallCnt != expStall) begin
      errors++;
      $display("FAIL fill_stall_len got %0d required %0d", stallCnt, expStall);
    end
    checks++;
    if (fillCnt != 4 || tagCnt != 1) begin
      errors++;
      $display("FAIL fill_pulses fillWe=%0d tagWe=%0d required 4 1", fillCnt, tagCnt);
    end
    checks++;
    if (missCount !== expMiss) begin
      errors++;
      $display("FAIL fill_missCount got %h required %h", missCount, expMiss);
    end
  endtask

  task automatic test_branch_pending();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      setHit();
      if (c == 0) begin hitIn = 1'b0; addressIn = 16'h0046; end
      if (c >= 1 && c <= 4) begin memAck = 1'b1; memData = 16'hB000; end
      if (c == 2) begin PcSrc = 1'b1; BranchTarget = 16'h0100; end
      if (c == 5) begin PcSrc = 1'b1; BranchTarget = 16'h0200; end
      #1;
      if (c >= 1 && c <= 5) begin
        checks++;
        if (pcSrcOut !== 1'b0 || stallOut !== 1'b1) begin
          errors++;
          $display("FAIL branch_held c=%0d pcSrcOut=%b stallOut=%b required 0 1", c, pcSrcOut, stallOut);
        end
      end
      if (c == 5) begin
        checks++;
        if (tagWe !== 1'b1) begin
          errors++;
          $display("FAIL branch_tagwr_cycle tagWe=%b required 1", tagWe);
        end
      end
      if (c == 6) begin
        checks++;
        if (pcSrcOut !== 1'b1 || branchTargetOut !== 16'h0200 || stallOut !== 1'b1) begin
          errors++;
          $display("FAIL branch_done pcSrcOut=%b tgt=%h stallOut=%b required 1 0200 1",
                   pcSrcOut, branchTargetOut, stallOut);
        end
      end
      if (c == 7) begin
        checks++;
        if (pcSrcOut !== 1'b0 || stallOut !== 1'b0) begin
          errors++;
          $display("FAIL branch_cleared pcSrcOut=%b stallOut=%b required 0 0", pcSrcOut, stallOut);
        end
      end
    end
  endtask

  task automatic test_miss_redirect(input logic [15:0] expMiss);
    @(negedge clk);
    setHit();
    hitIn = 1'b0; addressIn = 16'h0046; PcSrc = 1'b1; BranchTarget = 16'h0300;
    #1;
    checks++;
    if (pcSrcOut !== 1'b1 || branchTargetOut !== 16'h0300 || stallOut !== 1'b0) begin
      errors++;
      $display("FAIL redirect_wins pcSrcOut=%b tgt=%h stallOut=%b required 1 0300 0",
               pcSrcOut, branchTargetOut, stallOut);
    end
    @(negedge clk);
    setHit();
    #1;
    checks++;
    if (memReq !== 1'b0 || missCount !== expMiss) begin
      errors++;
      $display("FAIL redirect_nofill memReq=%b missCount=%h required 0 %h", memReq, missCount, expMiss);
    end
  endtask

  task automatic test_reset_midfill();
    int bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      setHit();
      if (c == 0) begin hitIn = 1'b0; addressIn = 16'h0046; end
      else begin memAck = 1'b1; memData = 16'hC000; end
    end
    @(negedge clk);
    memAck = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || tagWe !== 1'b0 || stallOut !== 1'b0 || missCount !== 16'h0000) begin
      errors++;
      $display("FAIL midfill_reset memReq=%b tagWe=%b stallOut=%b missCount=%h required 0 0 0 0000",
               memReq, tagWe, stallOut, missCount);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    setHit();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (tagWe !== 1'b0 || memReq !== 1'b0 || stallOut !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || missCount !== 16'h0000) begin
      errors++;
      $display("FAIL midfill_after bad_cycles=%0d missCount=%h required 0 0000", bad, missCount);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      test_fill(0, 16'(i + 1));
      if (i == 2) begin
        checks++;
        if (missCount2 !== 2'd3) begin
          errors++;
          $display("FAIL sat_reach got %0d required 3", missCount2);
        end
      end
    end
    checks++;
    if (missCount2 !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold got %0d required 3", missCount2);
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_fill(0, 16'h0001);
    test_fill(2, 16'h0002);
    test_branch_pending();
    test_miss_redirect(16'h0003);
    test_reset_midfill();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
